wishbone_master_arbiter: RTL

//  Two-master round-robin arbiter in front of the wishbone interconnect's single master port.

---
 rtl/wishbone_master_arbiter_pkg.sv | 14 +
 rtl/wishbone_arbiter_watchdog.sv | 34 +++
 rtl/wishbone_master_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wishbone_master_arbiter_pkg.sv
// Shared state encoding and helpers for the two-master wishbone arbiter.
`default_nettype none

package wishbone_master_arbiter_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    typedef logic [1:0] state_t;

endpackage

`default_nettype wire

// File: rtl/wishbone_arbiter_watchdog.sv
// Stall watchdog: counts unacked strobe cycles of the bus owner and flags a forced completion.
`default_nettype none

module wishbone_arbiter_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    output logic tmo_hit
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] wdog;

    // A real ack in the hit cycle takes priority over the forced completion.
    assign tmo_hit = stb & ~ack & (wdog == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if (stb & ~ack & ~tmo_hit) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wishbone_master_arbiter.sv
// Two-master round-robin wishbone arbiter; grant held for a whole cyc, watchdog-protected strobes.
`default_nettype none

module wishbone_master_arbiter
    import wishbone_master_arbiter_pkg::*;
#(
    parameter int          TIMEOUT  = 256,
    parameter logic [31:0] TMO_DATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_int_o,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_int_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_int_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    state_t state;
    state_t next_state;
    logic   last;
    logic   own0;
    logic   own1;
    logic   owner_stb;
    logic   tmo_hit;
    logic [31:0] ret_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE) begin
                last <= (next_state == GNT1);
            end
        end
    end

    // IDLE always separates owners, so handover costs exactly one dead cycle.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) next_state = last ? GNT0 : GNT1;
                else if (m0_cyc_i)        next_state = GNT0;
                else if (m1_cyc_i)        next_state = GNT1;
                else                      next_state = IDLE;
            end
            GNT0:    next_state = m0_cyc_i ? GNT0 : IDLE;
            GNT1:    next_state = m1_cyc_i ? GNT1 : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        own0    = (state == GNT0);
        own1    = (state == GNT1);
        grant_o = {own1, own0};
    end

    always_comb begin
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (own0) begin
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (own1) begin
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

    wishbone_arbiter_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .stb     (owner_stb),
        .ack     (s_ack_i),
        .tmo_hit (tmo_hit)
    );

    always_comb begin
        ret_dat   = tmo_hit ? TMO_DATA : s_dat_i;
        m0_dat_o  = own0 ? ret_dat : 32'h0;
        m1_dat_o  = own1 ? ret_dat : 32'h0;
        m0_ack_o  = own0 & (s_ack_i | tmo_hit);
        m1_ack_o  = own1 & (s_ack_i | tmo_hit);
        m0_int_o  = s_int_i;
        m1_int_o  = s_int_i;
        timeout_o = tmo_hit;
    end

endmodule

`default_nettype wire
